// File: rtl/muldiv_pkg.sv
// ============================================================================
// Module      : muldiv_pkg
// Description : Operation and FSM state encodings shared by the iterative
//               multiply/divide unit and the instruction decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package muldiv_pkg;

  localparam logic [1:0] OP_MUL   = 2'd0;
  localparam logic [1:0] OP_MULHU = 2'd1;
  localparam logic [1:0] OP_DIVU  = 2'd2;
  localparam logic [1:0] OP_REMU  = 2'd3;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Divide ops share op[1]; op[0] selects the high accumulator word.
  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_takes_high(input logic [1:0] op);
    return op[0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_unit.sv
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative radix-2 unsigned multiply / divide unit with a
//               single shared add/subtract datapath and register write-back.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DBITS = 32,
  parameter int ABITS = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [DBITS-1:0] srcA,
  input  logic [DBITS-1:0] srcB,
  input  logic [ABITS-1:0] dstInd,
  output logic             busy,
  output logic             wrtEn,
  output logic [ABITS-1:0] wrtInd,
  output logic [DBITS-1:0] dOut
);

  localparam int CNT_W = $clog2(DBITS) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DBITS - 1);

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;
  logic [ABITS-1:0]   dst_q, dst_d;
  logic [DBITS-1:0]   divisor_q, divisor_d;
  logic [2*DBITS-1:0] acc_q, acc_d;

  logic               is_div;
  logic [DBITS:0]     alu_x;
  logic [DBITS:0]     alu_y;
  logic [DBITS:0]     alu_r;
  logic [2*DBITS-1:0] acc_step;

  // Multiply adds B into the high word then shifts right; divide shifts the
  // partial remainder left and trial-subtracts B, the MSB of the result being
  // the borrow. Divide by zero falls out naturally as Q=all ones, R=A.
  always_comb begin
    is_div = op_is_div(op_q);
    if (is_div) begin
      alu_x = acc_q[2*DBITS-1:DBITS-1];
      alu_y = {1'b0, divisor_q};
      alu_r = alu_x - alu_y;
    end else begin
      alu_x = {1'b0, acc_q[2*DBITS-1:DBITS]};
      alu_y = {1'b0, (acc_q[0] ? divisor_q : {DBITS{1'b0}})};
      alu_r = alu_x + alu_y;
    end

    if (!is_div) begin
      acc_step = {alu_r, acc_q[DBITS-1:1]};
    end else if (alu_r[DBITS]) begin
      acc_step = {acc_q[2*DBITS-2:0], 1'b0};
    end else begin
      acc_step = {alu_r[DBITS-1:0], acc_q[DBITS-2:0], 1'b1};
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    dst_d     = dst_q;
    divisor_d = divisor_q;
    acc_d     = acc_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_CALC;
          cnt_d     = '0;
          op_d      = op;
          dst_d     = dstInd;
          divisor_d = srcB;
          acc_d     = {{DBITS{1'b0}}, srcA};
        end
      end
      S_CALC: begin
        acc_d = acc_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= OP_MUL;
      dst_q     <= '0;
      divisor_q <= '0;
      acc_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      dst_q     <= dst_d;
      divisor_q <= divisor_d;
      acc_q     <= acc_d;
    end
  end

  always_comb begin
    busy   = (state_q != S_IDLE);
    wrtEn  = (state_q == S_DONE);
    wrtInd = '0;
    dOut   = '0;
    if (state_q == S_DONE) begin
      wrtInd = dst_q;
      dOut   = op_takes_high(op_q) ? acc_q[2*DBITS-1:DBITS] : acc_q[DBITS-1:0];
    end
  end

endmodule

`default_nettype wire
